// File: rtl/xgriscv_lsu.sv
// Load/store unit: one aligned memory cycle per request, or byte-serial
// splitting of misaligned half/word accesses, with a one-cycle response.
module xgriscv_lsu #(
    parameter int unsigned SPLIT_MISALIGNED = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        mem_we,
    output logic [3:0]  mem_amp,
    output logic [31:0] mem_a,
    output logic [31:0] mem_wd,
    input  logic [31:0] mem_rd,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        busy
);
    typedef enum logic [1:0] {StIdle, StAcc, StSplit, StResp} state_t;

    state_t      state_q, state_d;
    logic [31:0] addr_q, wdata_q, asm_q, rdata_q;
    logic [1:0]  size_q, k_q;
    logic        we_q, uns_q, err_q;

    logic        accept, req_misal, req_bad, split_last;
    logic [1:0]  last_k, lane;
    logic [31:0] cur_a, rd_shift, wd_shift, assembled, load_raw, load_ext;
    logic [7:0]  rd_byte, wd_byte;

    always_comb begin
        req_ready  = (state_q == StIdle) || (state_q == StResp);
        busy       = ~req_ready;
        accept     = req_valid && req_ready;
        req_misal  = ((req_size == 2'b01) && req_addr[0]) ||
                     ((req_size == 2'b10) && (req_addr[1:0] != 2'b00));
        req_bad    = (req_size == 2'b11) || (req_misal && (SPLIT_MISALIGNED == 0));
        last_k     = (size_q == 2'b01) ? 2'd1 : 2'd3;
        split_last = (k_q == last_k);
        cur_a      = addr_q + {30'd0, k_q};
        lane       = (state_q == StSplit) ? cur_a[1:0] : addr_q[1:0];
        rd_shift   = mem_rd >> {lane, 3'b000};
        rd_byte    = rd_shift[7:0];
        wd_shift   = wdata_q >> {k_q, 3'b000};
        wd_byte    = wd_shift[7:0];
        // Split loads finish with the last byte taken straight from mem_rd.
        assembled  = asm_q;
        assembled[{k_q, 3'b000} +: 8] = rd_byte;

        if (state_q == StSplit) begin
            load_raw = assembled;
        end else begin
            case (size_q)
                2'b10:   load_raw = mem_rd;
                2'b01:   load_raw = addr_q[1] ? {16'd0, mem_rd[31:16]} : {16'd0, mem_rd[15:0]};
                default: load_raw = {24'd0, rd_byte};
            endcase
        end

        case (size_q)
            2'b00:   load_ext = uns_q ? {24'd0, load_raw[7:0]}
                                      : {{24{load_raw[7]}}, load_raw[7:0]};
            2'b01:   load_ext = uns_q ? {16'd0, load_raw[15:0]}
                                      : {{16{load_raw[15]}}, load_raw[15:0]};
            default: load_ext = load_raw;
        endcase
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle, StResp: begin
                if (accept) begin
                    state_d = req_bad ? StResp : (req_misal ? StSplit : StAcc);
                end else begin
                    state_d = StIdle;
                end
            end
            StAcc:   state_d = StResp;
            StSplit: state_d = split_last ? StResp : StSplit;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        mem_we     = 1'b0;
        mem_amp    = 4'b0000;
        mem_a      = 32'd0;
        mem_wd     = 32'd0;
        resp_valid = (state_q == StResp);
        resp_err   = resp_valid && err_q;
        resp_rdata = resp_valid ? rdata_q : 32'd0;
        case (state_q)
            StAcc: begin
                mem_a = addr_q;
                if (we_q) begin
                    mem_we = 1'b1;
                    case (size_q)
                        2'b10: begin
                            mem_amp = 4'b1111;
                            mem_wd  = wdata_q;
                        end
                        2'b01: begin
                            mem_amp = addr_q[1] ? 4'b1100 : 4'b0011;
                            mem_wd  = {16'd0, wdata_q[15:0]};
                        end
                        default: begin
                            mem_amp = 4'b0001 << addr_q[1:0];
                            mem_wd  = {24'd0, wdata_q[7:0]};
                        end
                    endcase
                end
            end
            StSplit: begin
                mem_a = cur_a;
                if (we_q) begin
                    mem_we  = 1'b1;
                    mem_amp = 4'b0001 << cur_a[1:0];
                    mem_wd  = {24'd0, wd_byte};
                end
            end
            default: ;
        endcase
        // Reset must never let a write strobe reach memory.
        if (reset) begin
            mem_we  = 1'b0;
            mem_amp = 4'b0000;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            asm_q   <= 32'd0;
            rdata_q <= 32'd0;
            size_q  <= 2'd0;
            k_q     <= 2'd0;
            we_q    <= 1'b0;
            uns_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
                size_q  <= req_size;
                we_q    <= req_we;
                uns_q   <= req_unsigned;
                err_q   <= req_bad;
                k_q     <= 2'd0;
                asm_q   <= 32'd0;
                rdata_q <= 32'd0;
            end else if (state_q == StAcc) begin
                rdata_q <= we_q ? 32'd0 : load_ext;
            end else if (state_q == StSplit) begin
                asm_q <= assembled;
                k_q   <= k_q + 2'd1;
                if (split_last) begin
                    rdata_q <= we_q ? 32'd0 : load_ext;
                end
            end
        end
    end
endmodule

// File: tb/tb_xgriscv_lsu.sv
// Self-checking bench for xgriscv_lsu: directed cases plus random traffic
// against a byte-addressed reference memory.
module tb_xgriscv_lsu;
    logic        clk = 1'b0;
    logic        reset, req_valid, req_we, req_unsigned;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata;

    logic        req_ready, mem_we, resp_valid, resp_err, busy;
    logic [3:0]  mem_amp;
    logic [31:0] mem_a, mem_wd, mem_rd, resp_rdata;

    logic        z_req_ready, z_mem_we, z_resp_valid, z_resp_err, z_busy;
    logic [3:0]  z_mem_amp;
    logic [31:0] z_mem_a, z_mem_wd, z_mem_rd, z_resp_rdata;

    logic [7:0]  bmem [256];
    logic [7:0]  rmem [256];

    logic [31:0] q_a [$];
    logic [3:0]  q_amp [$];
    logic [31:0] q_wd [$];
    logic        q_we [$];

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    xgriscv_lsu #(.SPLIT_MISALIGNED(1)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .req_we(req_we), .req_size(req_size), .req_unsigned(req_unsigned),
        .req_addr(req_addr), .req_wdata(req_wdata), .mem_we(mem_we), .mem_amp(mem_amp),
        .mem_a(mem_a), .mem_wd(mem_wd), .mem_rd(mem_rd), .resp_valid(resp_valid),
        .resp_rdata(resp_rdata), .resp_err(resp_err), .busy(busy)
    );

    xgriscv_lsu #(.SPLIT_MISALIGNED(0)) dut0 (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(z_req_ready),
        .req_we(req_we), .req_size(req_size), .req_unsigned(req_unsigned),
        .req_addr(req_addr), .req_wdata(req_wdata), .mem_we(z_mem_we), .mem_amp(z_mem_amp),
        .mem_a(z_mem_a), .mem_wd(z_mem_wd), .mem_rd(z_mem_rd), .resp_valid(z_resp_valid),
        .resp_rdata(z_resp_rdata), .resp_err(z_resp_err), .busy(z_busy)
    );

    // Memory aliases every 256 bytes.
    always_comb begin
        mem_rd = {bmem[{mem_a[7:2], 2'd3}], bmem[{mem_a[7:2], 2'd2}],
                  bmem[{mem_a[7:2], 2'd1}], bmem[{mem_a[7:2], 2'd0}]};
        z_mem_rd = {bmem[{z_mem_a[7:2], 2'd3}], bmem[{z_mem_a[7:2], 2'd2}],
                    bmem[{z_mem_a[7:2], 2'd1}], bmem[{z_mem_a[7:2], 2'd0}]};
    end

    task automatic set_byte(input logic [31:0] a, input logic [7:0] v);
        bmem[a[7:0]] = v;
        rmem[a[7:0]] = v;
    endtask

    // Lane j receives write-data byte (j - lowest enabled lane).
    task automatic apply_write();
        int lo;
        logic [31:0] t;
        logic [7:0] idx;
        if (mem_we === 1'b1) begin
            lo = 0;
            for (int j = 3; j >= 0; j--) if (mem_amp[j]) lo = j;
            for (int j = 0; j < 4; j++) begin
                if (mem_amp[j]) begin
                    t = mem_wd >> (8 * (j - lo));
                    idx = {mem_a[7:2], 2'(j)};
                    bmem[idx] = t[7:0];
                end
            end
        end
    endtask

    function automatic logic [31:0] ref_load(input logic [1:0] sz, input logic uns,
                                             input logic [31:0] a);
        int n;
        logic [31:0] v, ai;
        n = 1 << sz;
        v = 0;
        for (int i = 0; i < n; i++) begin
            ai = a + i;
            v = v | (32'(rmem[ai[7:0]]) << (8 * i));
        end
        if (!uns && n < 4 && v[8*n-1]) v = v - (32'd1 << (8 * n));
        return v;
    endfunction

    task automatic ref_store(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] wd);
        logic [31:0] ai, t;
        for (int i = 0; i < (1 << sz); i++) begin
            ai = a + i;
            t = wd >> (8 * i);
            rmem[ai[7:0]] = t[7:0];
        end
    endtask

    function automatic int exp_lat(input logic [1:0] sz, input logic [31:0] a);
        if (sz == 2'd3) return 1;
        if ((a % (32'd1 << sz)) != 0) return (1 << sz) + 1;
        return 2;
    endfunction

    // Called at a negedge; returns at the negedge of the response cycle.
    task automatic do_op(input logic we, input logic [1:0] sz, input logic uns,
                         input logic [31:0] a, input logic [31:0] wd,
                         output int lat, output logic [31:0] rd, output logic er);
        req_valid = 1'b1; req_we = we; req_size = sz; req_unsigned = uns;
        req_addr = a; req_wdata = wd;
        checks++;
        if (req_ready !== 1'b1) begin
            failures++;
            $display("FAIL accept_ready: req_ready=%b want 1 (addr %h)", req_ready, a);
        end
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        q_a.delete(); q_amp.delete(); q_wd.delete(); q_we.delete();
        lat = -1; rd = 32'hx; er = 1'bx;
        for (int n = 1; n <= 8; n++) begin
            q_a.push_back(mem_a); q_amp.push_back(mem_amp);
            q_wd.push_back(mem_wd); q_we.push_back(mem_we);
            apply_write();
            if (resp_valid === 1'b1) begin
                lat = n; rd = resp_rdata; er = resp_err;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checks++;
            if (req_ready !== 1'b1 || resp_valid !== 1'b0 || mem_we !== 1'b0) begin
                failures++;
                $display("FAIL reset_hold: ready=%b valid=%b we=%b want 1 0 0",
                         req_ready, resp_valid, mem_we);
            end
        end
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if ({req_ready, busy, resp_valid, resp_err, resp_rdata, mem_we, mem_amp, mem_a, mem_wd}
            !== {1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 4'd0, 32'd0, 32'd0}) begin
            failures++;
            $display("FAIL reset_state: ready=%b busy=%b v=%b e=%b rd=%h we=%b amp=%b a=%h wd=%h",
                     req_ready, busy, resp_valid, resp_err, resp_rdata, mem_we, mem_amp,
                     mem_a, mem_wd);
        end
    endtask

    task automatic test_sw_aligned();
        int lat; logic [31:0] rd; logic er;
        do_op(1'b1, 2'd2, 1'b0, 32'h100, 32'hDEADBEEF, lat, rd, er);
        ref_store(2'd2, 32'h100, 32'hDEADBEEF);
        checks++;
        if ({q_we[0], q_amp[0], q_a[0], q_wd[0]} !== {1'b1, 4'b1111, 32'h100, 32'hDEADBEEF}) begin
            failures++;
            $display("FAIL sw_cycle: we=%b amp=%b a=%h wd=%h want 1 1111 100 deadbeef",
                     q_we[0], q_amp[0], q_a[0], q_wd[0]);
        end
        checks++;
        if (lat != 2 || rd !== 32'd0 || er !== 1'b0) begin
            failures++;
            $display("FAIL sw_resp: lat=%0d rd=%h err=%b want 2 0 0", lat, rd, er);
        end
    endtask

    task automatic test_lh();
        int lat; logic [31:0] rd; logic er;
        set_byte(32'h100, 8'h34); set_byte(32'h101, 8'h12);
        set_byte(32'h102, 8'h01); set_byte(32'h103, 8'h80);
        do_op(1'b0, 2'd1, 1'b0, 32'h102, 32'd0, lat, rd, er);
        checks++;
        if (lat != 2 || rd !== 32'hFFFF8001 || er !== 1'b0) begin
            failures++;
            $display("FAIL lh_signed: lat=%0d rd=%h want 2 ffff8001", lat, rd);
        end
        do_op(1'b0, 2'd1, 1'b1, 32'h102, 32'd0, lat, rd, er);
        checks++;
        if (lat != 2 || rd !== 32'h00008001 || er !== 1'b0) begin
            failures++;
            $display("FAIL lhu: lat=%0d rd=%h want 2 00008001", lat, rd);
        end
    endtask

    task automatic test_split_store();
        int lat; logic [31:0] rd; logic er;
        logic [31:0] ea [4];
        logic [3:0]  eamp [4];
        logic [7:0]  ewd [4];
        ea = '{32'h101, 32'h102, 32'h103, 32'h104};
        eamp = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};
        ewd = '{8'h11, 8'h22, 8'h33, 8'h44};
        do_op(1'b1, 2'd2, 1'b0, 32'h101, 32'h44332211, lat, rd, er);
        ref_store(2'd2, 32'h101, 32'h44332211);
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (q_a.size() <= k || {q_we[k], q_a[k], q_amp[k], q_wd[k][7:0]}
                !== {1'b1, ea[k], eamp[k], ewd[k]}) begin
                failures++;
                $display("FAIL split_store_k%0d: got a/amp/wd %h/%b/%h want %h/%b/%h", k,
                         (q_a.size() > k) ? q_a[k] : 32'hx, (q_a.size() > k) ? q_amp[k] : 4'hx,
                         (q_a.size() > k) ? q_wd[k][7:0] : 8'hx, ea[k], eamp[k], ewd[k]);
            end
        end
        checks++;
        if (lat != 5 || rd !== 32'd0) begin
            failures++;
            $display("FAIL split_store_resp: lat=%0d rd=%h want 5 0", lat, rd);
        end
    endtask

    task automatic test_split_load_wrap();
        int lat; logic [31:0] rd; logic er;
        logic [31:0] ea [4];
        ea = '{32'hFFFFFFFF, 32'h0, 32'h1, 32'h2};
        set_byte(32'hFF, 8'hA1); set_byte(32'h00, 8'hB2);
        set_byte(32'h01, 8'hC3); set_byte(32'h02, 8'hD4);
        do_op(1'b0, 2'd2, 1'b0, 32'hFFFFFFFF, 32'd0, lat, rd, er);
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (q_a.size() <= k || q_a[k] !== ea[k] || q_we[k] !== 1'b0) begin
                failures++;
                $display("FAIL wrap_addr_k%0d: a=%h we=%b want %h 0", k,
                         (q_a.size() > k) ? q_a[k] : 32'hx, (q_we.size() > k) ? q_we[k] : 1'bx,
                         ea[k]);
            end
        end
        checks++;
        if (lat != 5 || rd !== 32'hD4C3B2A1 || er !== 1'b0) begin
            failures++;
            $display("FAIL wrap_load: lat=%0d rd=%h want 5 d4c3b2a1", lat, rd);
        end
    endtask

    task automatic test_back_to_back();
        int lat; logic [31:0] rd; logic [31:0] exp; logic er;
        set_byte(32'h40, 8'h10); set_byte(32'h41, 8'hF2);
        set_byte(32'h42, 8'h93); set_byte(32'h43, 8'h7C);
        do_op(1'b0, 2'd2, 1'b0, 32'h40, 32'd0, lat, rd, er);
        checks++;
        if (req_ready !== 1'b1 || busy !== 1'b0 || rd !== 32'h7C93F210) begin
            failures++;
            $display("FAIL b2b_first: ready=%b busy=%b rd=%h want 1 0 7c93f210",
                     req_ready, busy, rd);
        end
        do_op(1'b1, 2'd0, 1'b0, 32'h43, 32'hABCDEF5E, lat, rd, er);
        ref_store(2'd0, 32'h43, 32'hABCDEF5E);
        checks++;
        if (lat != 2 || q_amp[0] !== 4'b1000 || q_wd[0] !== 32'h5E) begin
            failures++;
            $display("FAIL b2b_sb: lat=%0d amp=%b wd=%h want 2 1000 5e", lat, q_amp[0], q_wd[0]);
        end
        exp = ref_load(2'd1, 1'b1, 32'h41);
        do_op(1'b0, 2'd1, 1'b1, 32'h41, 32'd0, lat, rd, er);
        checks++;
        if (lat != 3 || rd !== exp) begin
            failures++;
            $display("FAIL b2b_lhu_split: lat=%0d rd=%h want 3 %h", lat, rd, exp);
        end
    endtask

    task automatic test_reset_split();
        bit seen;
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_size = 2'd2; req_unsigned = 1'b0;
        req_addr = 32'h201; req_wdata = 32'h55667788;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        apply_write();
        ref_store(2'd0, 32'h201, 32'h88);
        @(negedge clk);
        checks++;
        if (mem_a !== 32'h202 || mem_we !== 1'b1) begin
            failures++;
            $display("FAIL rst_split_k1: a=%h we=%b want 202 1", mem_a, mem_we);
        end
        reset = 1'b1;
        #1;
        checks++;
        if (mem_we !== 1'b0 || mem_amp !== 4'b0000) begin
            failures++;
            $display("FAIL rst_gate: we=%b amp=%b want 0 0000", mem_we, mem_amp);
        end
        @(negedge clk);
        checks++;
        if (req_ready !== 1'b1 || resp_valid !== 1'b0 || mem_we !== 1'b0 || mem_a !== 32'd0) begin
            failures++;
            $display("FAIL rst_abort: ready=%b valid=%b we=%b a=%h want 1 0 0 0",
                     req_ready, resp_valid, mem_we, mem_a);
        end
        reset = 1'b0;
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (resp_valid !== 1'b0 || mem_we !== 1'b0) seen = 1;
        end
        checks++;
        if (seen) begin
            failures++;
            $display("FAIL rst_quiet: activity=1 want 0 after aborted split");
        end
    endtask

    task automatic test_err();
        int lat; logic [31:0] rd; logic er;
        bit ok;
        req_valid = 1'b1; req_we = 1'b0; req_size = 2'd2; req_unsigned = 1'b0;
        req_addr = 32'h102; req_wdata = 32'h0;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        checks++;
        if ({z_resp_valid, z_resp_err, z_resp_rdata, z_mem_we} !== {1'b1, 1'b1, 32'd0, 1'b0}) begin
            failures++;
            $display("FAIL nosplit_err: v=%b e=%b rd=%h we=%b want 1 1 0 0",
                     z_resp_valid, z_resp_err, z_resp_rdata, z_mem_we);
        end
        ok = 0;
        for (int i = 0; i < 8 && !ok; i++) begin
            if (resp_valid === 1'b1) ok = 1;
            else @(negedge clk);
        end
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL split_drain: resp_valid never seen, want 1 within 8 cycles");
        end
        do_op(1'b0, 2'd3, 1'b0, 32'h200, 32'd0, lat, rd, er);
        checks++;
        if (lat != 1 || er !== 1'b1 || rd !== 32'd0 || q_we[0] !== 1'b0) begin
            failures++;
            $display("FAIL illegal_size: lat=%0d err=%b rd=%h we=%b want 1 1 0 0",
                     lat, er, rd, q_we[0]);
        end
    endtask

    task automatic test_random();
        int lat, el; logic [31:0] rd, a, exp, m, wd; logic er, we, uns; logic [1:0] sz;
        bit wrote;
        for (int i = 0; i < 120; i++) begin
            we = 1'($urandom_range(0, 1));
            uns = 1'($urandom_range(0, 1));
            sz = ($urandom_range(0, 7) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            a = $urandom;
            wd = $urandom;
            m = (sz == 2'd2) ? 32'hFFFFFFFC : ((sz == 2'd1) ? 32'hFFFFFFFE : 32'hFFFFFFFF);
            if ($urandom_range(0, 1) == 1) a = a & m;
            el = exp_lat(sz, a);
            exp = (we || sz == 2'd3) ? 32'd0 : ref_load(sz, uns, a);
            do_op(we, sz, uns, a, wd, lat, rd, er);
            checks++;
            if (lat != el || rd !== exp || er !== (sz == 2'd3)) begin
                failures++;
                $display("FAIL rand_%0d: we=%b sz=%0d a=%h lat=%0d rd=%h err=%b want %0d %h %b",
                         i, we, sz, a, lat, rd, er, el, exp, (sz == 2'd3));
            end
            if (!we || sz == 2'd3) begin
                wrote = 0;
                foreach (q_we[j]) if (q_we[j] !== 1'b0) wrote = 1;
                checks++;
                if (wrote) begin
                    failures++;
                    $display("FAIL rand_nowrite_%0d: mem_we seen=1 want 0", i);
                end
            end else begin
                ref_store(sz, a, wd);
            end
            if ($urandom_range(0, 3) == 0) @(negedge clk);
        end
    endtask

    initial begin
        req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0; req_unsigned = 1'b0;
        req_addr = 32'd0; req_wdata = 32'd0; reset = 1'b1;
        for (int i = 0; i < 256; i++) begin
            bmem[i] = 8'($urandom);
            rmem[i] = bmem[i];
        end
        test_reset();
        test_sw_aligned();
        test_lh();
        test_split_store();
        test_split_load_wrap();
        test_back_to_back();
        test_reset_split();
        test_err();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/xgriscv_lsu.md
XGRISCV_LSU -- requirements
Module: xgriscv_lsu

Interface
REQ-001 Parameter: SPLIT_MISALIGNED, 1, 1 = split misaligned accesses into byte transactions; 0 = reject them with resp_err.
REQ-002 clk  in  1  clock; all state updates on rising edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 req_valid  in  1  pipeline presents a memory operation.
REQ-005 req_ready  out  1  LSU can accept; transfer occurs when req_valid & req_ready at a rising edge.
REQ-006 req_we  in  1  1 = store, 0 = load.
REQ-007 req_size  in  2  00 byte, 01 half, 10 word, 11 illegal.
REQ-008 req_unsigned  in  1  loads only; 1 = zero-extend (lbu/lhu), 0 = sign-extend.
REQ-009 req_addr  in  32  byte address.
REQ-010 req_wdata  in  32  store data, low-justified.
REQ-011 mem_we  out  1  data-memory write enable.
REQ-012 mem_amp  out  4  byte-lane mask: 1111, 0011, 1100, 0001, 0010, 0100 or 1000 only.
REQ-013 mem_a  out  32  data-memory address.
REQ-014 mem_wd  out  32  write data, low-justified: word in [31:0], half in [15:0], byte in [7:0].
REQ-015 mem_rd  in  32  word read from memory at mem_a[31:2], valid in the same cycle.
REQ-016 resp_valid  out  1  one-cycle completion pulse.
REQ-017 resp_rdata  out  32  extended load result; 0 for stores and errors.
REQ-018 resp_err  out  1  with resp_valid: illegal size, or misaligned access with SPLIT_MISALIGNED=0.
REQ-019 busy  out  1  = ~req_ready; pipeline stall.

Function
REQ-020 States: IDLE, ACC (single aligned access), SPLIT (byte-serial access), RESP (completion cycle).
REQ-021 req_ready is 1 in IDLE and RESP; an accepted request captures addr, size, we, unsigned and wdata into registers.
REQ-022 Aligned: byte any address, half addr[0]=0, word addr[1:0]=00; transitions accept -> ACC -> RESP, so resp_valid rises 2 cycles after accept.
REQ-023 ACC drives mem_a=addr and mem_we=we; mem_amp is 1111 for a word, 0011/1100 for a half by addr[1], one-hot of addr[1:0] for a byte.
REQ-024 Misaligned with SPLIT_MISALIGNED=1: SPLIT runs N = 2 (half) or 4 (word) cycles; cycle k (0..N-1) drives mem_a=addr+k and mem_amp=one-hot((addr+k)[1:0]).
REQ-025 In SPLIT cycle k of a store, mem_wd[7:0] = wdata byte k and mem_we=1.
REQ-026 In SPLIT cycle k of a load, mem_rd byte (addr+k)[1:0] is latched into assembly byte k.
REQ-027 After SPLIT cycle N-1 the state goes to RESP; resp_valid rises N+1 cycles after accept.
REQ-028 addr+k is 32-bit modular, so 0xFFFFFFFF+1 wraps to 0x00000000.
REQ-029 Load result: selected byte/half is sign- or zero-extended to 32 bits and registered into resp_rdata when entering RESP.
REQ-030 Illegal size, or misaligned access with SPLIT_MISALIGNED=0: no memory cycle, mem_we stays 0; next cycle is RESP with resp_err=1 and resp_rdata=0.
REQ-031 mem_we=0 and mem_amp=0000 in IDLE and RESP, during loads, and in any cycle where reset=1.
REQ-032 Accepting in RESP is back-to-back: the next state is ACC, SPLIT or RESP(err) per the new request, never IDLE.
REQ-033 RESP with no new request returns to IDLE.
REQ-034 resp_valid, resp_err and resp_rdata are held only during RESP; resp_valid=0 and resp_err=0 otherwise.

Reset
REQ-035 reset=1 at a rising edge forces IDLE from any state, aborting an in-progress split without completing it and without a resp_valid.
REQ-036 After reset: req_ready=1, busy=0, resp_valid=0, resp_err=0, resp_rdata=0, mem_we=0, mem_amp=0000, mem_a=0, mem_wd=0.

Verification
REQ-037 Reset: reset high 2 cycles then low -> req_ready=1, resp_valid=0, mem_we=0 throughout.
REQ-038 sw addr 0x100, data 0xDEADBEEF -> T+1 mem_we=1, amp=1111, a=0x100, wd=0xDEADBEEF; T+2 resp_valid=1, rdata=0.
REQ-039 lh addr 0x102 with mem_rd=0x80011234 -> resp_rdata=0xFFFF8001; same access as lhu -> 0x00008001.
REQ-040 sw addr 0x101, data 0x44332211 (split=1):
- a/amp/wd[7:0] sequence 0x101/0010/11, 0x102/0100/22, 0x103/1000/33, 0x104/0001/44;
- resp_valid at T+5.
REQ-041 lw addr 0xFFFFFFFF -> mem_a sequence 0xFFFFFFFF, 0x0, 0x1, 0x2; bytes assembled in order; resp at T+5.
REQ-042 Reset and error cases:
- reset asserted during SPLIT cycle k=1 -> next cycle IDLE, mem_we=0, no resp_valid;
- SPLIT_MISALIGNED=0 with lw at 0x102 -> T+1 resp_valid=1, resp_err=1, no mem_we.
